gc_response_rx: RTL and testbench

//  Receives and decodes the 64-bit controller status reply that follows each poll command on the controller data line.

---
 rtl/gc_response_rx.sv | 180 ++++++++++++++++++
 tb/tb_gc_response_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_response_rx.sv
// gc_response_rx: times the low pulses of a controller reply on the data line,
// assembles the 64 data bits MSB-first, checks the stop bit and publishes the
// last good report split into its fields.
module gc_response_rx #(
  parameter int SAMPLE_CYC  = 200,
  parameter int LOW_MAX_CYC = 450,
  parameter int GAP_MAX_CYC = 600,
  parameter int ARM_TMO_CYC = 10000,
  parameter int RESP_BITS   = 64
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        arm,
  input  logic        data_in,
  output logic        busy,
  output logic        report_valid,
  output logic        rx_error,
  output logic [1:0]  err_code,
  output logic [63:0] report,
  output logic [15:0] buttons,
  output logic [7:0]  joy_x,
  output logic [7:0]  joy_y,
  output logic [7:0]  c_x,
  output logic [7:0]  c_y,
  output logic [7:0]  trig_l,
  output logic [7:0]  trig_r
);

  localparam int CNT_W  = 16;
  localparam int NBIT_W = $clog2(RESP_BITS + 1);

  localparam logic [CNT_W-1:0]  SAMPLE_AT = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0]  LOW_MAX   = CNT_W'(LOW_MAX_CYC);
  localparam logic [CNT_W-1:0]  GAP_MAX   = CNT_W'(GAP_MAX_CYC);
  localparam logic [CNT_W-1:0]  ARM_TMO   = CNT_W'(ARM_TMO_CYC);
  localparam logic [NBIT_W-1:0] LAST_BIT  = NBIT_W'(RESP_BITS);

  localparam logic [1:0] ERR_NOREPLY = 2'd0;
  localparam logic [1:0] ERR_STUCK   = 2'd1;
  localparam logic [1:0] ERR_GAP     = 2'd2;
  localparam logic [1:0] ERR_BADSTOP = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    LOW,
    HIGH,
    FINISH
  } rxState_t;

  rxState_t          state;
  logic              syncMeta;
  logic              ds;
  logic              dsPrev;
  logic [CNT_W-1:0]  cnt;
  logic [NBIT_W-1:0] nbit;
  logic [63:0]       sh;
  logic              sampled;
  logic              fall;

  // Two-flop synchroniser plus one history flop for edge detection; idle line is high
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      syncMeta <= 1'b1;
      ds       <= 1'b1;
      dsPrev   <= 1'b1;
    end else begin
      syncMeta <= data_in;
      ds       <= syncMeta;
      dsPrev   <= ds;
    end
  end

  assign fall = dsPrev & ~ds;

  // Reception FSM: pulse timing, bit assembly, stop check and registered status outputs
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state        <= IDLE;
      cnt          <= '0;
      nbit         <= '0;
      sh           <= '0;
      sampled      <= 1'b0;
      busy         <= 1'b0;
      report_valid <= 1'b0;
      rx_error     <= 1'b0;
      err_code     <= ERR_NOREPLY;
      report       <= '0;
    end else begin
      report_valid <= 1'b0;
      rx_error     <= 1'b0;
      if (cnt != '1) cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (arm) begin
            state <= WAIT_START;
            cnt   <= '0;
            sh    <= '0;
            nbit  <= '0;
            busy  <= 1'b1;
          end
        end

        WAIT_START: begin
          if (fall) begin
            state   <= LOW;
            cnt     <= '0;
            sampled <= 1'b0;
          end else if (cnt == ARM_TMO) begin
            state <= FINISH; cnt <= '0; busy <= 1'b0;
            rx_error <= 1'b1; err_code <= ERR_NOREPLY;
          end
        end

        LOW: begin
          if (cnt == SAMPLE_AT) begin
            if (nbit == LAST_BIT) begin
              // Stop bit: a short low (sampled high) closes the reply
              state <= FINISH; cnt <= '0; busy <= 1'b0;
              if (ds) begin
                report       <= sh;
                report_valid <= 1'b1;
              end else begin
                rx_error <= 1'b1;
                err_code <= ERR_BADSTOP;
              end
            end else begin
              sh      <= {sh[62:0], ds};
              nbit    <= nbit + 1'b1;
              sampled <= 1'b1;
              if (ds) begin
                state <= HIGH;
                cnt   <= '0;
              end
            end
          end else if (sampled && ds) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (!ds && cnt == LOW_MAX) begin
            state <= FINISH; cnt <= '0; busy <= 1'b0;
            rx_error <= 1'b1; err_code <= ERR_STUCK;
          end
        end

        HIGH: begin
          if (fall) begin
            state   <= LOW;
            cnt     <= '0;
            sampled <= 1'b0;
          end else if (cnt == GAP_MAX) begin
            state <= FINISH; cnt <= '0; busy <= 1'b0;
            rx_error <= 1'b1; err_code <= ERR_GAP;
          end
        end

        // One-cycle completion slot; an arm seen here is dropped
        FINISH: begin
          state <= IDLE;
          cnt   <= '0;
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign buttons = report[63:48];
  assign joy_x   = report[47:40];
  assign joy_y   = report[39:32];
  assign c_x     = report[31:24];
  assign c_y     = report[23:16];
  assign trig_l  = report[15:8];
  assign trig_r  = report[7:0];

endmodule

// File: tb/tb_gc_response_rx.sv
// Bench for gc_response_rx with timing scaled down 10x (bit cell = 40 cycles).
module tb_gc_response_rx;

  localparam int SAMPLE = 20;
  localparam int LOWMAX = 45;
  localparam int GAPMAX = 60;
  localparam int TMO    = 1000;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        arm = 1'b0;
  logic        data_in = 1'b1;
  logic        busy, report_valid, rx_error;
  logic [1:0]  err_code;
  logic [63:0] report;
  logic [15:0] buttons;
  logic [7:0]  joy_x, joy_y, c_x, c_y, trig_l, trig_r;

  int nAsserts = 0;
  int nFails = 0;
  int validCount = 0;
  int errCount = 0;
  int overlapCount = 0;
  logic busyAtValid = 1'b1;
  logic [63:0] expReport = '0;

  gc_response_rx #(
    .SAMPLE_CYC(SAMPLE), .LOW_MAX_CYC(LOWMAX), .GAP_MAX_CYC(GAPMAX),
    .ARM_TMO_CYC(TMO), .RESP_BITS(64)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .arm(arm), .data_in(data_in),
    .busy(busy), .report_valid(report_valid), .rx_error(rx_error),
    .err_code(err_code), .report(report), .buttons(buttons),
    .joy_x(joy_x), .joy_y(joy_y), .c_x(c_x), .c_y(c_y),
    .trig_l(trig_l), .trig_r(trig_r)
  );

  always #5 PCLK = ~PCLK;

  // Event monitor on the falling edge
  always @(negedge PCLK) begin
    if (PRESERN) begin
      if (report_valid) begin
        validCount  <= validCount + 1;
        busyAtValid <= busy;
      end
      if (rx_error) errCount <= errCount + 1;
      if (report_valid && rx_error) overlapCount <= overlapCount + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic armPulse();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  // One bit cell: a 1 is a short low, a 0 a long low; jittered within legal bounds
  task automatic sendCell(input logic b);
    int lowCyc, highCyc;
    lowCyc  = b ? $urandom_range(15, 5) : $urandom_range(38, 25);
    highCyc = b ? $urandom_range(32, 25) : $urandom_range(15, 8);
    data_in = 1'b0;
    tick(lowCyc);
    data_in = 1'b1;
    tick(highCyc);
  endtask

  // stopKind: 0 none, 1 good stop, 2 stop cell driven as a 0
  task automatic sendReply(input logic [63:0] v, input int nbits, input int stopKind);
    for (int i = 0; i < nbits; i++) sendCell(v[63-i]);
    if (stopKind == 1) sendCell(1'b1);
    else if (stopKind == 2) sendCell(1'b0);
  endtask

  task automatic test_reset();
    tick(3);
    nAsserts++;
    if ({busy, report_valid, rx_error, err_code, report} !== 69'd0) begin
      nFails++;
      $display("FAIL reset_outputs: got busy=%b rv=%b err=%b code=%0d report=%h, want all 0",
               busy, report_valid, rx_error, err_code, report);
    end
    nAsserts++;
    if ({buttons, joy_x, joy_y, c_x, c_y, trig_l, trig_r} !== 64'd0) begin
      nFails++;
      $display("FAIL reset_fields: got %h %h %h %h %h %h %h, want 0",
               buttons, joy_x, joy_y, c_x, c_y, trig_l, trig_r);
    end
    PRESERN = 1'b1;
    tick(5);
  endtask

  task automatic test_good_reply(input logic [63:0] v, input string name);
    int v0, e0;
    v0 = validCount; e0 = errCount;
    armPulse();
    tick(3);
    sendReply(v, 64, 1);
    tick(20);
    expReport = v;
    $display("reply %s: sent %h, report %h", name, v, report);
    nAsserts++;
    if (validCount - v0 != 1) begin nFails++; $display("FAIL %s_valid_count: got %0d, want 1", name, validCount - v0); end
    nAsserts++;
    if (errCount != e0) begin nFails++; $display("FAIL %s_no_error: got %0d errors, want 0", name, errCount - e0); end
    nAsserts++;
    if (report !== expReport) begin nFails++; $display("FAIL %s_report: got %h, want %h", name, report, expReport); end
    nAsserts++;
    if ({buttons, joy_x, joy_y, c_x, c_y, trig_l, trig_r} !==
        {expReport[63:48], expReport[47:40], expReport[39:32], expReport[31:24],
         expReport[23:16], expReport[15:8], expReport[7:0]}) begin
      nFails++;
      $display("FAIL %s_fields: got %h %h %h %h %h %h %h, want slices of %h",
               name, buttons, joy_x, joy_y, c_x, c_y, trig_l, trig_r, expReport);
    end
    nAsserts++;
    if (busyAtValid !== 1'b0) begin nFails++; $display("FAIL %s_busy_at_valid: got %b, want 0", name, busyAtValid); end
  endtask

  task automatic test_noreply();
    int e0, k;
    e0 = errCount;
    armPulse();
    k = 0;
    while (k < 2 * TMO) begin
      @(posedge PCLK); #1;
      k++;
      if (rx_error) break;
    end
    $display("noreply: rx_error after %0d cycles, code %0d", k, err_code);
    nAsserts++;
    if (k != TMO + 1) begin nFails++; $display("FAIL noreply_latency: got %0d cycles, want %0d", k, TMO + 1); end
    tick(200);
    nAsserts++;
    if (err_code !== 2'd0) begin nFails++; $display("FAIL noreply_code: got %0d, want 0", err_code); end
    nAsserts++;
    if (report !== expReport) begin nFails++; $display("FAIL noreply_report_kept: got %h, want %h", report, expReport); end
    nAsserts++;
    if (errCount - e0 != 1 || busy !== 1'b0) begin
      nFails++; $display("FAIL noreply_once: got %0d errors busy=%b, want 1 and 0", errCount - e0, busy);
    end
  endtask

  // Runs an aborted reply and checks the resulting error code and that no report was produced
  task automatic test_abort(input int nbits, input int stopKind, input int stuckLow,
                            input logic [1:0] wantCode, input string name);
    int v0, e0;
    v0 = validCount; e0 = errCount;
    armPulse();
    tick(3);
    sendReply({$urandom, $urandom}, nbits, stopKind);
    if (stuckLow > 0) begin
      data_in = 1'b0;
      tick(stuckLow);
      data_in = 1'b1;
    end
    tick(150);
    $display("abort %s: code %0d, errors %0d, reports %0d", name, err_code, errCount - e0, validCount - v0);
    nAsserts++;
    if (err_code !== wantCode) begin nFails++; $display("FAIL %s_code: got %0d, want %0d", name, err_code, wantCode); end
    nAsserts++;
    if (errCount - e0 != 1 || validCount != v0) begin
      nFails++; $display("FAIL %s_events: got %0d errors %0d reports, want 1 and 0", name, errCount - e0, validCount - v0);
    end
    nAsserts++;
    if (busy !== 1'b0 || report !== expReport) begin
      nFails++; $display("FAIL %s_state: got busy=%b report=%h, want 0 and %h", name, busy, report, expReport);
    end
  endtask

  task automatic test_arm_while_busy();
    logic [63:0] v;
    int v0, e0;
    v = {$urandom, $urandom};
    v0 = validCount; e0 = errCount;
    fork
      begin
        armPulse();
        tick(3);
        sendReply(v, 64, 1);
      end
      begin
        tick(600);
        nAsserts++;
        if (busy !== 1'b1) begin nFails++; $display("FAIL rearm_busy: got %b, want 1", busy); end
        armPulse();
      end
    join
    tick(20);
    expReport = v;
    $display("rearm: sent %h, report %h", v, report);
    nAsserts++;
    if (validCount - v0 != 1 || errCount != e0) begin
      nFails++; $display("FAIL rearm_events: got %0d reports %0d errors, want 1 and 0", validCount - v0, errCount - e0);
    end
    nAsserts++;
    if (report !== expReport) begin nFails++; $display("FAIL rearm_report: got %h, want %h", report, expReport); end
  endtask

  task automatic test_reset_mid_reply();
    int v0, e0;
    armPulse();
    tick(3);
    sendReply({$urandom, $urandom}, 30, 0);
    PRESERN = 1'b0;
    tick(2);
    expReport = '0;
    $display("mid-reply reset: report %h busy %b code %0d", report, busy, err_code);
    nAsserts++;
    if ({busy, report_valid, rx_error, err_code, report, buttons, trig_r} !== 93'd0) begin
      nFails++;
      $display("FAIL midreset_outputs: got busy=%b rv=%b err=%b code=%0d report=%h, want all 0",
               busy, report_valid, rx_error, err_code, report);
    end
    tick(3);
    PRESERN = 1'b1;
    tick(2);
    v0 = validCount; e0 = errCount;
    sendReply({$urandom, $urandom}, 10, 0);
    tick(100);
    nAsserts++;
    if (busy !== 1'b0 || validCount != v0 || errCount != e0 || report !== expReport) begin
      nFails++;
      $display("FAIL midreset_ignore: got busy=%b reports=%0d errors=%0d report=%h, want 0 0 0 %h",
               busy, validCount - v0, errCount - e0, report, expReport);
    end
    test_good_reply({$urandom, $urandom}, "after_reset");
  endtask

  initial begin
    test_reset();
    test_good_reply(64'h0080_7F80_8080_1F1F, "fixed");
    nAsserts++;
    if (joy_x !== 8'h7F || trig_r !== 8'h1F) begin
      nFails++; $display("FAIL fixed_joy_trig: got joy_x=%h trig_r=%h, want 7f 1f", joy_x, trig_r);
    end
    for (int i = 0; i < 2; i++) test_good_reply({$urandom, $urandom}, "random");
    test_good_reply(64'hFFFF_FFFF_FFFF_FFFF, "all_ones");
    test_noreply();
    test_abort(10, 0, 60, 2'd1, "stuck");
    test_good_reply({$urandom, $urandom}, "after_stuck");
    test_abort(64, 2, 0, 2'd3, "badstop");
    test_abort(64, 0, 0, 2'd2, "gap");
    test_arm_while_busy();
    test_reset_mid_reply();
    nAsserts++;
    if (overlapCount != 0) begin nFails++; $display("FAIL valid_error_overlap: got %0d cycles, want 0", overlapCount); end
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
